fetch_decode_ctrl: RTL
======================

Name: fetch_decode_ctrl

Overview:
- Sequences instruction fetch and decode for the CPU front end.
- Issues word fetches on the instruction bus, passes each returned word through the combinational `decoder` sub-module, and registers the decoded fields.
- Presents decoded fields to the execute stage with a valid/ready handshake.
- Owns the fetch PC and handles redirects (branch/jump/trap) from execute, including flushing an in-flight fetch.

Parameters:
- RESET_PC, 32'h00000000, fetch address after reset; bits [1:0] must be 0.

Ports:
- I_clk  in  1  clock, all state changes on rising edge
- I_reset  in  1  synchronous, active-high reset
- O_bus_req  out  1  fetch request; held until I_bus_ack
- O_bus_addr  out  32  fetch address; stable while O_bus_req=1
- I_bus_data  in  32  instruction word; valid in the I_bus_ack cycle
- I_bus_ack  in  1  fetch complete
- I_redirect  in  1  redirect request, single-cycle pulse
- I_redirect_pc  in  32  redirect target; bits [1:0] forced to 0
- O_valid  out  1  decoded instruction available
- I_ready  in  1  execute accepts; handshake completes when O_valid & I_ready
- O_pc  out  32  address of the presented instruction
- O_instr  out  32  raw instruction word
- O_rs1, O_rs2, O_rd  out  5 each  register fields
- O_imm  out  32  sign-extended immediate
- O_opcode  out  5  opcode, bits [6:2]
- O_funct3  out  3  funct3
- O_funct7  out  7  funct7
- O_illegal  out  1  illegal-encoding flag (see Optional Feature)

Behaviour:
- States: S_FETCH, S_HOLD, S_DRAIN.
- O_bus_req is 1 in S_FETCH and S_DRAIN, combinationally from state. O_bus_addr = fetch_pc in S_FETCH and issued_pc in S_DRAIN.
- Reset:
  - state=S_FETCH, fetch_pc=RESET_PC, O_valid=0.
  - All registered decode outputs, O_pc, O_instr and O_illegal = 0.
  - O_bus_req=0 during the reset cycle and =1 in the first cycle after reset.
  - Reset mid-transaction drops the request immediately; the bus shares the same reset.
- S_FETCH, I_bus_ack=1, no redirect:
  - Register I_bus_data, its decoded fields and O_pc=fetch_pc.
  - O_valid=1 next cycle; fetch_pc += 4 (wraps modulo 2^32); go to S_HOLD.
- S_FETCH, no ack, no redirect: stay in S_FETCH.
- S_HOLD:
  - Outputs are stable while O_valid=1 and I_ready=0.
  - On I_ready=1: O_valid=0 next cycle; go to S_FETCH.
  - Steady-state throughput is at most one instruction per 2 cycles plus bus latency. Minimum latency is ack cycle -> O_valid on the next edge.
- Redirect (priority over every other event):
  - S_HOLD: O_valid=0 next cycle, fetch_pc=I_redirect_pc, go to S_FETCH. Redirect together with I_ready counts as a completed handshake followed by the redirect; same resulting state.
  - S_FETCH with ack in the same cycle: discard the word, fetch_pc=I_redirect_pc, stay in S_FETCH (new address next cycle).
  - S_FETCH without ack: issued_pc=fetch_pc, fetch_pc=I_redirect_pc, go to S_DRAIN.
- S_DRAIN:
  - Keep request and old address until ack; then discard the data and go to S_FETCH.
  - A further redirect in S_DRAIN overwrites fetch_pc (last wins).
  - O_valid=0 throughout.
- O_valid never asserts for a word fetched before a redirect.

Optional Feature:
- Macro: FETCH_ILLEGAL_CHECK_EN.
- Defined: O_illegal is registered alongside the fields and set when either condition holds:
  - instr[1:0] != 2'b11, or
  - opcode is not one of LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP, OP_IMM, MISC_MEM, SYSTEM.
- Defined: an illegal instruction is still presented with O_valid=1; execute traps.
- Undefined: O_illegal is tied to 0 and no check logic is generated. The port exists in both builds.

Decomposition:
- State encodings S_FETCH/S_HOLD/S_DRAIN go in the shared riscvdefs.vh define file, alongside the existing OP_* opcode constants.
- The illegal-check opcode list reuses the OP_* constants.
- One sub-module: an instance of the existing combinational `decoder`, fed from I_bus_data; its outputs are registered here.

Test Plan:
- Reset with RESET_PC=0; bus acks after 2 cycles with 32'h00500093 -> O_bus_addr=0, then O_valid=1 with O_pc=0, rd=1, rs1=0, imm=5, opcode=5'b00100; next fetch address=4.
- Hold I_ready=0 for 5 cycles while presenting 32'hFE112E23 -> all outputs stable; imm=32'hFFFFFFFC, rs1=2, rs2=1; no bus request until I_ready=1.
- Redirect to 32'h100 while a fetch of address 8 is un-acked -> address stays 8 until ack, data discarded, O_valid stays 0, next request at 32'h100.
- Redirect to 32'h203 coinciding with ack -> word dropped, next O_bus_addr=32'h200.
- Assert I_reset while in S_HOLD -> next cycle O_valid=0, O_bus_req=1, O_bus_addr=RESET_PC.
- With FETCH_ILLEGAL_CHECK_EN defined, fetch 32'h00000000 -> O_valid=1, O_illegal=1; 32'h00000013 -> O_illegal=0.

Source files
------------

// File: rtl/fetch_decode_ctrl_pkg.sv
// Shared front-end definitions: fetch FSM states, RV32 major opcodes (bits [6:2])
// and the opcode-legality helper used by the optional illegal-encoding check.
package fetch_decode_ctrl_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [4:0] OP_LOAD     = 5'b00000;
    localparam logic [4:0] OP_MISC_MEM = 5'b00011;
    localparam logic [4:0] OP_OP_IMM   = 5'b00100;
    localparam logic [4:0] OP_AUIPC    = 5'b00101;
    localparam logic [4:0] OP_STORE    = 5'b01000;
    localparam logic [4:0] OP_OP       = 5'b01100;
    localparam logic [4:0] OP_LUI      = 5'b01101;
    localparam logic [4:0] OP_BRANCH   = 5'b11000;
    localparam logic [4:0] OP_JALR     = 5'b11001;
    localparam logic [4:0] OP_JAL      = 5'b11011;
    localparam logic [4:0] OP_SYSTEM   = 5'b11100;

    function automatic logic is_known_opcode(input logic [4:0] op);
        return op inside {OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI,
                          OP_AUIPC, OP_OP, OP_OP_IMM, OP_MISC_MEM, OP_SYSTEM};
    endfunction

endpackage

// File: rtl/fetch_decode_ctrl_decoder.sv
// Combinational RV32 field extractor; the immediate is sign-extended per format.
// Formats without an immediate (OP and unknown opcodes) yield 0.
module decoder
    import fetch_decode_ctrl_pkg::*;
(
    input  logic [31:2] instr,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic [4:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7
);

    assign opcode = instr[6:2];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    always_comb begin
        imm = '0;
        case (instr[6:2])
            OP_LOAD, OP_OP_IMM, OP_JALR, OP_MISC_MEM, OP_SYSTEM:
                imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {instr[31:12], 12'b0};
            OP_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// CPU front end: fetch PC, bus request sequencing, redirect/flush and registered decode.
// Optional macro FETCH_ILLEGAL_CHECK_EN enables the registered illegal-encoding flag.
module fetch_decode_ctrl
    import fetch_decode_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        I_clk,
    input  logic        I_reset,
    output logic        O_bus_req,
    output logic [31:0] O_bus_addr,
    input  logic [31:0] I_bus_data,
    input  logic        I_bus_ack,
    input  logic        I_redirect,
    input  logic [31:0] I_redirect_pc,
    output logic        O_valid,
    input  logic        I_ready,
    output logic [31:0] O_pc,
    output logic [31:0] O_instr,
    output logic [4:0]  O_rs1,
    output logic [4:0]  O_rs2,
    output logic [4:0]  O_rd,
    output logic [31:0] O_imm,
    output logic [4:0]  O_opcode,
    output logic [2:0]  O_funct3,
    output logic [6:0]  O_funct7,
    output logic        O_illegal
);

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] issued_pc;
    logic [31:0] redirect_target;

    logic [4:0]  dec_rs1, dec_rs2, dec_rd, dec_opcode;
    logic [31:0] dec_imm;
    logic [2:0]  dec_funct3;
    logic [6:0]  dec_funct7;

    decoder u_decoder (
        .instr  (I_bus_data[31:2]),
        .rs1    (dec_rs1),
        .rs2    (dec_rs2),
        .rd     (dec_rd),
        .imm    (dec_imm),
        .opcode (dec_opcode),
        .funct3 (dec_funct3),
        .funct7 (dec_funct7)
    );

    assign redirect_target = I_redirect_pc & ~32'h3;

    // The request drops in the reset cycle itself; the bus shares this reset.
    assign O_bus_req  = !I_reset && (state == S_FETCH || state == S_DRAIN);
    assign O_bus_addr = (state == S_DRAIN) ? issued_pc : fetch_pc;

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state     <= S_FETCH;
            fetch_pc  <= RESET_PC;
            issued_pc <= '0;
            O_valid   <= 1'b0;
            O_pc      <= '0;
            O_instr   <= '0;
            O_rs1     <= '0;
            O_rs2     <= '0;
            O_rd      <= '0;
            O_imm     <= '0;
            O_opcode  <= '0;
            O_funct3  <= '0;
            O_funct7  <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (I_redirect) begin
                        // An acked word is simply dropped; an un-acked fetch must be drained.
                        fetch_pc <= redirect_target;
                        if (!I_bus_ack) begin
                            issued_pc <= fetch_pc;
                            state     <= S_DRAIN;
                        end
                    end else if (I_bus_ack) begin
                        O_valid  <= 1'b1;
                        O_pc     <= fetch_pc;
                        O_instr  <= I_bus_data;
                        O_rs1    <= dec_rs1;
                        O_rs2    <= dec_rs2;
                        O_rd     <= dec_rd;
                        O_imm    <= dec_imm;
                        O_opcode <= dec_opcode;
                        O_funct3 <= dec_funct3;
                        O_funct7 <= dec_funct7;
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (I_redirect) begin
                        O_valid  <= 1'b0;
                        fetch_pc <= redirect_target;
                        state    <= S_FETCH;
                    end else if (I_ready) begin
                        O_valid <= 1'b0;
                        state   <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (I_redirect) begin
                        fetch_pc <= redirect_target;
                    end
                    if (I_bus_ack) begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

`ifdef FETCH_ILLEGAL_CHECK_EN
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            O_illegal <= 1'b0;
        end else if (state == S_FETCH && I_bus_ack && !I_redirect) begin
            O_illegal <= (I_bus_data[1:0] != 2'b11) || !is_known_opcode(I_bus_data[6:2]);
        end
    end
`else
    assign O_illegal = 1'b0;
`endif

endmodule
